fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined LEGv8 processor. It holds the PC and issues word fetches to an instruction memory over a request/grant/response handshake, with one request outstanding at a time. Fetched words go into an IF/ID pipeline register with a valid bit, a one-entry skid buffer, stall support and taken-branch redirect. It replaces the bare PC/IF-ID flops between imem and the controller/datapath.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC, single-outstanding imem request/grant/response
// handshake, IF/ID register with one-entry skid buffer, stall and branch redirect.
module fetch_unit #(
    parameter int             N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             OPC_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [N-1:0]      br_target,
    output logic              im_req,
    output logic [N-1:0]      im_addr,
    input  logic              im_gnt,
    input  logic              im_rvalid,
    input  logic [31:0]       im_rdata,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [N-1:0]      if_id_pc,
    output logic [OPC_W-1:0]  if_id_opcode,
    output logic [N-1:0]      pc_out
);

    // state  | meaning
    // S_REQ  | request the word at pc (held off while the skid is full)
    // S_WAIT | one request outstanding, waiting for im_rvalid
    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t       state;
    logic [N-1:0] pc;
    logic [N-1:0] req_pc;
    logic         drop;
    logic         skid_valid;
    logic [31:0]  skid_instr;
    logic [N-1:0] skid_pc;

    logic         fire;
    logic         deliver;
    logic [N-1:0] pc_inc;
    logic [N-1:0] br_aligned;
    logic         unused_br_low;

    assign im_req        = (state == S_REQ) && !skid_valid && !reset;
    assign fire          = im_req && im_gnt;
    assign deliver       = (state == S_WAIT) && im_rvalid && !drop && !br_taken;
    assign pc_inc        = pc + N'(4);
    assign br_aligned    = {br_target[N-1:2], 2'b00};
    assign unused_br_low = ^br_target[1:0];

    assign im_addr      = {pc[N-1:2], 2'b00};
    assign pc_out       = pc;
    assign if_id_opcode = if_id_instr[31 -: OPC_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
            drop   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (fire) begin
                        state  <= S_WAIT;
                        req_pc <= pc;
                        // a grant coinciding with a redirect belongs to the old PC
                        drop   <= br_taken;
                        pc     <= br_taken ? br_aligned : pc_inc;
                    end else if (br_taken) begin
                        pc <= br_aligned;
                    end
                end
                S_WAIT: begin
                    if (br_taken)
                        pc <= br_aligned;
                    if (im_rvalid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else if (br_taken) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else if (br_taken) begin
            if_id_valid <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (stall && if_id_valid) begin
            // skid cannot already be full here: a full skid suppresses requests
            if (deliver) begin
                skid_valid <= 1'b1;
                skid_instr <= im_rdata;
                skid_pc    <= req_pc;
            end
        end else if (skid_valid) begin
            if_id_valid <= 1'b1;
            if_id_instr <= skid_instr;
            if_id_pc    <= skid_pc;
            skid_valid  <= 1'b0;
        end else if (deliver) begin
            if_id_valid <= 1'b1;
            if_id_instr <= im_rdata;
            if_id_pc    <= req_pc;
        end else begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: imem model with variable grant/response latency and
// an in-order program-stream scoreboard that follows branch redirects.
module tb_fetch_unit;
    localparam int N = 64;

    logic          clk = 1'b0;
    logic          reset, stall, br_taken, im_gnt, im_rvalid;
    logic [N-1:0]  br_target;
    logic [31:0]   im_rdata;
    logic          im_req, if_id_valid;
    logic [N-1:0]  im_addr, if_id_pc, pc_out;
    logic [31:0]   if_id_instr;
    logic [10:0]   if_id_opcode;

    logic          reset16;
    logic          im_req16, if_id_valid16;
    logic [15:0]   im_addr16, if_id_pc16, pc_out16;
    logic [31:0]   if_id_instr16;
    logic [10:0]   if_id_opcode16;

    fetch_unit #(.N(64), .RESET_PC(64'h0), .OPC_W(11)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid),
        .im_rdata(im_rdata), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_opcode(if_id_opcode), .pc_out(pc_out));

    fetch_unit #(.N(16), .RESET_PC(16'hFFFC), .OPC_W(11)) dut16 (
        .clk(clk), .reset(reset16), .stall(1'b0), .br_taken(1'b0), .br_target(16'h0),
        .im_req(im_req16), .im_addr(im_addr16), .im_gnt(1'b1), .im_rvalid(1'b1),
        .im_rdata(32'hDEADBEEF), .if_id_valid(if_id_valid16), .if_id_instr(if_id_instr16),
        .if_id_pc(if_id_pc16), .if_id_opcode(if_id_opcode16), .pc_out(pc_out16));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model
    int          gdelay, rdelay, gcnt, rcnt;
    bit          pending, rand_delays, spurious_en;
    logic [63:0] paddr;
    logic [63:0] acc_addr[$];
    int          acc_cyc[$];
    int          cycle = 0;

    // program-stream scoreboard
    logic [63:0] exp_pc;
    int          consumed;

    logic        p_req, p_gnt, p_rvalid, p_stall, p_br, p_valid;
    logic [63:0] p_addr, p_tgt, p_pc;
    logic [31:0] p_instr;
    logic [10:0] p_opc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'hF800_0000;
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        pending = 0; gcnt = 0; rcnt = 0; exp_pc = 64'h0;
        acc_addr.delete(); acc_cyc.delete();
    endtask

    task automatic step(input bit st, input bit br, input logic [63:0] tgt);
        logic [31:0] w;
        @(negedge clk);
        stall = st; br_taken = br; br_target = tgt;
        im_gnt = im_req ? (gcnt >= gdelay) : (spurious_en && ($urandom_range(0, 1) == 1));
        if (pending && rcnt == 0) begin
            im_rvalid = 1'b1; im_rdata = mem_word(paddr);
        end else begin
            im_rvalid = 1'b0; im_rdata = $urandom;
        end
        #1;
        p_req = im_req; p_gnt = im_gnt; p_rvalid = im_rvalid; p_addr = im_addr;
        p_stall = stall; p_br = br_taken; p_tgt = br_target;
        p_valid = if_id_valid; p_pc = if_id_pc; p_instr = if_id_instr; p_opc = if_id_opcode;
        if (pending) begin
            checks++;
            if (im_req !== 1'b0) begin
                errors++; $display("FAIL overlap_req: im_req=%b while a request is outstanding, want 0", im_req);
            end
        end
        @(posedge clk); #1;
        cycle++;
        if (p_rvalid) pending = 0;
        else if (pending && rcnt > 0) rcnt--;
        if (p_req && p_gnt) begin
            pending = 1; paddr = p_addr; rcnt = rdelay; gcnt = 0;
            acc_addr.push_back(p_addr); acc_cyc.push_back(cycle);
            if (rand_delays) begin
                gdelay = $urandom_range(0, 3); rdelay = $urandom_range(0, 3);
            end
        end else if (p_req) gcnt++;
        else gcnt = 0;

        if (p_br) exp_pc = {p_tgt[63:2], 2'b00};
        else if (p_valid && !p_stall) begin
            w = mem_word(exp_pc);
            checks++;
            if (p_pc !== exp_pc || p_instr !== w || p_opc !== w[31:21]) begin
                errors++;
                $display("FAIL stream: got pc=%0h instr=%0h opc=%0h, want pc=%0h instr=%0h opc=%0h",
                         p_pc, p_instr, p_opc, exp_pc, w, w[31:21]);
            end
            exp_pc += 64'd4;
            consumed++;
        end
        if (!p_br && p_stall && p_valid) begin
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== p_pc || if_id_instr !== p_instr) begin
                errors++;
                $display("FAIL stall_hold: got v=%b pc=%0h instr=%0h, want v=1 pc=%0h instr=%0h",
                         if_id_valid, if_id_pc, if_id_instr, p_pc, p_instr);
            end
        end
        if (p_req && !p_gnt && !p_br) begin
            checks++;
            if (im_req !== 1'b1 || im_addr !== p_addr) begin
                errors++;
                $display("FAIL addr_stable: got req=%b addr=%0h, want req=1 addr=%0h", im_req, im_addr, p_addr);
            end
        end
        checks++;
        if (im_addr !== {pc_out[63:2], 2'b00}) begin
            errors++; $display("FAIL addr_align: got im_addr=%0h, want %0h", im_addr, {pc_out[63:2], 2'b00});
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (im_req !== 1'b0 || im_addr !== 64'h0 || pc_out !== 64'h0 || if_id_valid !== 1'b0 ||
            if_id_instr !== 32'h0 || if_id_pc !== 64'h0 || if_id_opcode !== 11'h0) begin
            errors++;
            $display("FAIL %s: got req=%b addr=%0h pc=%0h v=%b instr=%0h ipc=%0h opc=%0h, want all 0",
                     tag, im_req, im_addr, pc_out, if_id_valid, if_id_instr, if_id_pc, if_id_opcode);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (im_req !== 1'b1) begin
            errors++; $display("FAIL req_after_reset: got im_req=%b, want 1", im_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset16 = 1'b1; stall = 0; br_taken = 0; br_target = '0;
        im_gnt = 0; im_rvalid = 0; im_rdata = '0;
        gdelay = 0; rdelay = 0; rand_delays = 0; spurious_en = 0; consumed = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_values");
        release_reset();
    endtask

    task automatic test_basic();
        step(0, 0, '0);
        step(0, 0, '0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || if_id_instr !== 32'hF800_0000 ||
            if_id_opcode !== 11'h7C0) begin
            errors++;
            $display("FAIL first_fetch: got v=%b pc=%0h instr=%0h opc=%0h, want v=1 pc=0 instr=f8000000 opc=7c0",
                     if_id_valid, if_id_pc, if_id_instr, if_id_opcode);
        end
        repeat (4) step(0, 0, '0);
        checks++;
        if (acc_addr.size() < 3 || acc_addr[0] !== 64'h0 || acc_addr[1] !== 64'h4 || acc_addr[2] !== 64'h8 ||
            acc_cyc[1] - acc_cyc[0] != 2 || acc_cyc[2] - acc_cyc[1] != 2) begin
            errors++;
            $display("FAIL addr_seq: got %0d fetches, first=%0h, want 0,4,8 on alternate cycles",
                     acc_addr.size(), acc_addr.size() > 0 ? acc_addr[0] : 64'hx);
        end
    endtask

    task automatic test_stall_skid();
        logic [63:0] h_pc;
        int k = 0;
        while (!(if_id_valid && im_req) && k < 10) begin step(0, 0, '0); k++; end
        checks++;
        if (!(if_id_valid && im_req)) begin
            errors++; $display("FAIL stall_setup: got v=%b req=%b, want 1 1", if_id_valid, im_req);
        end
        h_pc = if_id_pc;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, '0);
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== h_pc) begin
                errors++; $display("FAIL stall_ifid: got pc=%0h, want %0h", if_id_pc, h_pc);
            end
            if (i >= 1) begin
                checks++;
                if (im_req !== 1'b0) begin
                    errors++; $display("FAIL skid_full_req: got im_req=%b, want 0", im_req);
                end
            end
        end
        step(0, 0, '0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== h_pc + 64'd4 || im_req !== 1'b1) begin
            errors++;
            $display("FAIL skid_drain: got v=%b pc=%0h req=%b, want v=1 pc=%0h req=1",
                     if_id_valid, if_id_pc, im_req, h_pc + 64'd4);
        end
    endtask

    task automatic test_branch_wait();
        int k = 0;
        int n0;
        rdelay = 2;
        while (!pending && k < 10) begin step(0, 0, '0); k++; end
        step(0, 1, 64'h103);
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++; $display("FAIL br_flush: got if_id_valid=%b, want 0", if_id_valid);
        end
        n0 = acc_addr.size();
        k = 0;
        while (acc_addr.size() == n0 && k < 12) begin step(0, 0, '0); k++; end
        checks++;
        if (acc_addr.size() == n0 || acc_addr[n0] !== 64'h100) begin
            errors++; $display("FAIL br_next_addr: got %0h, want 100", acc_addr.size() > n0 ? acc_addr[n0] : 64'hx);
        end
        k = 0;
        while (!if_id_valid && k < 12) begin step(0, 0, '0); k++; end
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 64'h100) begin
            errors++; $display("FAIL br_next_ifid: got v=%b pc=%0h, want v=1 pc=100", if_id_valid, if_id_pc);
        end
        rdelay = 0;
    endtask

    task automatic test_branch_grant();
        int k = 0;
        int n0;
        gdelay = 0; rdelay = 0;
        step(0, 1, 64'h20);
        while (!(im_req && pc_out == 64'h20) && k < 10) begin step(0, 0, '0); k++; end
        n0 = acc_addr.size();
        step(0, 1, 64'h200);
        checks++;
        if (acc_addr.size() != n0 + 1 || pc_out !== 64'h200) begin
            errors++;
            $display("FAIL br_grant_pc: got pc=%0h grants=%0d, want pc=200 grants=1", pc_out, acc_addr.size() - n0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, '0);
            checks++;
            if (if_id_valid && if_id_pc == 64'h20) begin
                errors++; $display("FAIL br_grant_drop: got if_id_pc=%0h loaded, want never 20", if_id_pc);
            end
        end
        checks++;
        if (acc_addr.size() < n0 + 2 || acc_addr[n0 + 1] !== 64'h200) begin
            errors++; $display("FAIL br_grant_next: got %0h, want 200", acc_addr.size() > n0 + 1 ? acc_addr[n0 + 1] : 64'hx);
        end
    endtask

    task automatic test_slow_mem();
        int c0 = consumed;
        gdelay = 3; rdelay = 2;
        repeat (70) step(0, 0, '0);
        checks++;
        if (consumed - c0 < 8) begin
            errors++; $display("FAIL slow_mem_rate: got %0d instrs, want >= 8", consumed - c0);
        end
        gdelay = 0; rdelay = 0;
    endtask

    task automatic test_random();
        int c0 = consumed;
        rand_delays = 1; spurious_en = 1;
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, {$urandom, $urandom});
        checks++;
        if (consumed - c0 < 50) begin
            errors++; $display("FAIL random_progress: got %0d instrs, want >= 50", consumed - c0);
        end
        rand_delays = 0; spurious_en = 0; gdelay = 0; rdelay = 0;
    endtask

    task automatic test_reset_midflight();
        int k = 0;
        rdelay = 3;
        step(0, 1, 64'h0);
        while (!pending && k < 10) begin step(0, 0, '0); k++; end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_values("reset_async");
        im_gnt = 0; im_rvalid = 0;
        model_reset();
        rdelay = 0;
        release_reset();
        repeat (6) step(0, 0, '0);
        checks++;
        if (acc_addr.size() < 2 || acc_addr[0] !== 64'h0 || acc_addr[1] !== 64'h4) begin
            errors++; $display("FAIL restart: got %0d fetches first=%0h, want 0,4", acc_addr.size(),
                               acc_addr.size() > 0 ? acc_addr[0] : 64'hx);
        end
    endtask

    task automatic test_wrap16();
        @(negedge clk);
        reset16 = 1'b1;
        #1;
        checks++;
        if (im_req16 !== 1'b0 || im_addr16 !== 16'hFFFC || if_id_valid16 !== 1'b0) begin
            errors++; $display("FAIL n16_reset: got req=%b addr=%0h v=%b, want 0 fffc 0", im_req16, im_addr16, if_id_valid16);
        end
        @(posedge clk); #2;
        reset16 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (im_addr16 !== 16'h0000 || im_req16 !== 1'b1 || if_id_valid16 !== 1'b1 || if_id_pc16 !== 16'hFFFC ||
            if_id_instr16 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL n16_wrap: got addr=%0h req=%b v=%b pc=%0h, want 0 1 1 fffc",
                     im_addr16, im_req16, if_id_valid16, if_id_pc16);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_skid();
        test_branch_wait();
        test_branch_grant();
        test_slow_mem();
        test_random();
        test_reset_midflight();
        test_wrap16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
